halfduplex_bus_port: RTL

HALFDUPLEX_BUS_PORT -- requirements
Module: halfduplex_bus_port

---
 rtl/halfduplex_bus_port.sv | 121 ++++++++++++
 1 files changed

// File: rtl/halfduplex_bus_port.sv
// Half-duplex port onto a shared 8-bit tristate bus: writes drive the bus for a fixed
// window and then release it for a turnaround; reads wait a settle time before sampling.
module halfduplex_bus_port #(
    parameter int unsigned DRIVE_CYCLES  = 2,
    parameter int unsigned TURN_CYCLES   = 1,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       rx_req,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    inout  wire  [7:0] bus_data,
    output logic       bus_oe,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        TURN,
        SETTLE,
        SAMPLE
    } state_t;

    // Counters hold "cycles remaining minus one", so a state lasts load+1 cycles.
    localparam logic [3:0] LP_DRIVE_LOAD  = 4'(DRIVE_CYCLES - 1);
    localparam logic [3:0] LP_TURN_LOAD   = 4'(TURN_CYCLES - 1);
    localparam logic [3:0] LP_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic [7:0] r_hold;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       w_accept_wr;
    logic       w_capture;

    assign tx_ready = (r_state == IDLE) && !reset;
    assign busy     = (r_state != IDLE);
    assign bus_oe   = (r_state == DRIVE);
    assign bus_data = bus_oe ? r_hold : 'z;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_accept_wr  = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                // A simultaneous write and read resolves in favour of the write.
                if (tx_ready && tx_valid) begin
                    w_accept_wr  = 1'b1;
                    w_next_state = DRIVE;
                    w_cnt_next   = LP_DRIVE_LOAD;
                end else if (tx_ready && rx_req) begin
                    w_next_state = SETTLE;
                    w_cnt_next   = LP_SETTLE_LOAD;
                end
            end
            DRIVE: begin
                if (r_cnt == '0) begin
                    w_next_state = TURN;
                    w_cnt_next   = LP_TURN_LOAD;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            TURN: begin
                if (r_cnt == '0) begin
                    w_next_state = IDLE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            SETTLE: begin
                if (r_cnt == '0) begin
                    w_next_state = SAMPLE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            SAMPLE: begin
                w_capture    = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_hold     <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_cnt_next;
            r_rx_valid <= w_capture;
            if (w_accept_wr) begin
                r_hold <= tx_data;
            end
            if (w_capture) begin
                r_rx_data <= bus_data;
            end
        end
    end

endmodule
